// File: rtl/scc_pkg.sv
// Shared types and defaults for the scalar core memory stage.
package scc_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data memory request bus between the memory stage (master) and memory (slave).
interface mem_stage_if #(
  parameter int DATA_W = 32
);

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );

endinterface

// File: rtl/mem_timer.sv
// Ack timeout counter; expired fires on the last allowed wait cycle.
module mem_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // The count reaches TIMEOUT on the edge that ends this cycle.
  assign expired = enable && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results, runs one load/store at a time.
// Define MEM_ALIGN_CHECK_EN to fault misaligned memory ops instead of issuing.
module mem_stage #(
  parameter int DATA_W  = scc_pkg::DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ex_valid,
  input  logic [DATA_W-1:0]             ex_result,
  input  logic [DATA_W-1:0]             ex_store_data,
  input  logic                          ex_mem_read,
  input  logic                          ex_mem_write,
  input  logic                          ex_reg_write,
  input  logic [scc_pkg::REG_ADDR_W-1:0] ex_rd,
  output logic                          stall,
  mem_stage_if.master                   dmem,
  output logic                          wb_valid,
  output logic                          wb_reg_write,
  output logic [DATA_W-1:0]             wb_data,
  output logic [scc_pkg::REG_ADDR_W-1:0] wb_rd,
  output logic                          fault
);

  import scc_pkg::*;

  mem_state_t              state, state_n;
  logic                    req_q, req_n;
  logic                    we_q, we_n;
  logic [DATA_W-1:0]       addr_q, addr_n;
  logic [DATA_W-1:0]       wdata_q, wdata_n;
  logic [REG_ADDR_W-1:0]   rd_q, rd_n;
  logic                    rw_q, rw_n;
  logic                    wb_valid_n;
  logic                    wb_rw_n;
  logic [DATA_W-1:0]       wb_data_n;
  logic [REG_ADDR_W-1:0]   wb_rd_n;
  logic                    fault_n;
  logic                    mem_op;
  logic                    misaligned;
  logic                    tmr_clear;
  logic                    tmr_en;
  logic                    tmr_expired;

  assign mem_op = ex_mem_read | ex_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |ex_result[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign tmr_clear = (state == IDLE);
  assign tmr_en    = (state == ACCESS) && !dmem.dmem_ack;

  mem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_n    = state;
    req_n      = req_q;
    we_n       = we_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    rd_n       = rd_q;
    rw_n       = rw_q;
    wb_valid_n = 1'b0;
    wb_rw_n    = 1'b0;
    wb_data_n  = wb_data;
    wb_rd_n    = wb_rd;
    fault_n    = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          !ex_valid: ;
          mem_op && misaligned: begin
            wb_valid_n = 1'b1;
            wb_rd_n    = ex_rd;
            fault_n    = 1'b1;
          end
          mem_op && !misaligned: begin
            state_n = ACCESS;
            req_n   = 1'b1;
            we_n    = ex_mem_write;
            addr_n  = ex_result;
            wdata_n = ex_store_data;
            rd_n    = ex_rd;
            rw_n    = ex_reg_write;
          end
          default: begin
            wb_valid_n = 1'b1;
            wb_data_n  = ex_result;
            wb_rd_n    = ex_rd;
            wb_rw_n    = ex_reg_write;
          end
        endcase
      end
      ACCESS: begin
        unique case (1'b1)
          dmem.dmem_ack: begin
            state_n    = IDLE;
            req_n      = 1'b0;
            we_n       = 1'b0;
            wb_valid_n = 1'b1;
            wb_rd_n    = rd_q;
            if (!we_q) begin
              wb_data_n = dmem.dmem_rdata;
              wb_rw_n   = rw_q;
            end
          end
          tmr_expired: begin
            state_n    = IDLE;
            req_n      = 1'b0;
            we_n       = 1'b0;
            wb_valid_n = 1'b1;
            wb_rd_n    = rd_q;
            fault_n    = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      rw_q         <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      fault        <= 1'b0;
    end else begin
      state        <= state_n;
      req_q        <= req_n;
      we_q         <= we_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      rd_q         <= rd_n;
      rw_q         <= rw_n;
      wb_valid     <= wb_valid_n;
      wb_reg_write <= wb_rw_n;
      wb_data      <= wb_data_n;
      wb_rd        <= wb_rd_n;
      fault        <= fault_n;
    end
  end

  // Stall decodes the state register only, never an input.
  assign stall           = (state == ACCESS);
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_W, default 32: datapath and memory word width.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for dmem_ack, range 1..255.
REQ-003 Port clk  in  1  rising-edge clock.
REQ-004 Port rst  in  1  reset; synchronous, active-high.
REQ-005 Port ex_valid  in  1  EXE presents an instruction this cycle.
REQ-006 Port ex_result  in  DATA_W  EXE result; address for loads and stores, writeback data otherwise.
REQ-007 Port ex_store_data  in  DATA_W  store data from the register file.
REQ-008 Port ex_mem_read / ex_mem_write / ex_reg_write  in  1 each  control bits.
REQ-009 Port ex_rd  in  5  destination register.
REQ-010 Port stall  out  1  upstream must hold its inputs.
REQ-011 Port dmem_req / dmem_we  out  1 each  memory request and write enable.
REQ-012 Port dmem_addr / dmem_wdata  out  DATA_W each  request address and write data.
REQ-013 Port dmem_rdata  in  DATA_W  read data, valid with ack.
REQ-014 Port dmem_ack  in  1  one-cycle completion.
REQ-015 Port wb_valid / wb_reg_write  out  1 each  writeback strobe and write enable.
REQ-016 Port wb_data  out  DATA_W  writeback data.
REQ-017 Port wb_rd  out  5  writeback register.
REQ-018 Port fault  out  1  one-cycle error pulse.

Function
REQ-019 The stage SHALL use the FSM states IDLE and ACCESS; stall SHALL equal (state==ACCESS), registered, with no combinational input-to-stall path.
REQ-020 In IDLE, ex_valid with neither mem bit set SHALL produce, next cycle: wb_valid=1, wb_data=ex_result, wb_rd=ex_rd, wb_reg_write=ex_reg_write.
REQ-021 In IDLE, ex_valid with a mem bit set SHALL latch addr, data, rd and control; it SHALL assert dmem_req next cycle, with dmem_we=ex_mem_write, and enter ACCESS.
REQ-022 If ex_mem_read and ex_mem_write are both set, the stage SHALL treat the operation as a write.
REQ-023 In ACCESS, dmem_req/we/addr/wdata SHALL stay stable until dmem_ack; ex_* inputs SHALL be ignored.
REQ-024 On dmem_ack in ACCESS, next cycle: dmem_req=0, wb_valid=1, wb_rd=latched rd, state IDLE.
REQ-025 For a load completion, the outputs SHALL be wb_data=dmem_rdata captured on the ack cycle and wb_reg_write=latched reg_write; for a store completion, wb_reg_write=0.
REQ-026 A timeout counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack; at count==TIMEOUT the stage SHALL drop dmem_req, pulse fault, emit wb_valid=1 with wb_reg_write=0, and return to IDLE.
REQ-027 An ack arriving in the same cycle the count reaches TIMEOUT SHALL win; no fault.
REQ-028 dmem_ack while IDLE SHALL be ignored.
REQ-029 wb_valid and fault SHALL be single-cycle pulses; wb_data/wb_rd SHALL hold their last value otherwise.

Reset
REQ-030 rst SHALL force state=IDLE, counter=0, and stall, dmem_req, dmem_we, wb_valid, wb_reg_write and fault all =0, with dmem_addr, dmem_wdata, wb_data and wb_rd =0; mid-ACCESS reset SHALL abandon the request with no writeback.

Configuration
REQ-031 With MEM_ALIGN_CHECK_EN defined, a mem op with ex_result[1:0]!=0 SHALL issue no request and SHALL produce, next cycle: fault=1, wb_valid=1, wb_reg_write=0, and state remains IDLE.
REQ-032 Without MEM_ALIGN_CHECK_EN, the stage SHALL pass addresses unchanged and alignment SHALL never cause fault.

Structure
REQ-033 Package scc_pkg SHALL hold the mem_state_t enum (IDLE, ACCESS), REG_ADDR_W=5 and the default DATA_W.
REQ-034 The timeout counter SHALL be sub-module mem_timer (inputs clear and enable, output expired); no other sub-modules.

Verification
REQ-035 ALU op ex_result=0x0000_0042, rd=3, reg_write=1 -> next cycle wb_valid=1, wb_data=0x42, wb_rd=3, stall=0.
REQ-036 Load addr 0x100, ack after 3 cycles with rdata 0xDEAD_BEEF -> stall high 3 cycles, then wb_data=0xDEADBEEF, wb_reg_write=1.
REQ-037 Store addr 0x104, data 0x1234, ack immediate -> dmem_we=1, dmem_wdata=0x1234 for one req cycle, then wb_valid=1, wb_reg_write=0.
REQ-038 Load with no ack, TIMEOUT=4 -> after 4 ACCESS cycles fault=1, wb_reg_write=0, dmem_req=0; ack at cycle 4 instead -> no fault.
REQ-039 With MEM_ALIGN_CHECK_EN, load addr 0x102 -> no dmem_req, fault=1 next cycle; without the macro, dmem_addr=0x102 is requested.
REQ-040 rst asserted during ACCESS -> next cycle dmem_req=0, stall=0, wb_valid=0, and a later ack is ignored.
